sha3_axil_regbank: RTL and testbench
====================================

SHA3_AXIL_REGBANK -- requirements
Module: sha3_axil_regbank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, register and bus data width (32 or 64 only).
REQ-002 SHALL have parameter C_NUM_REGS, default 4, register count (power of 2, 2..64).
REQ-003 SHALL have parameter C_RO_MASK, default 0, C_NUM_REGS-bit mask where bit i=1 makes register i read-only.
REQ-004 SHALL derive C_S_AXI_ADDR_WIDTH = clog2(C_NUM_REGS)+clog2(C_S_AXI_DATA_WIDTH/8) and decode only the register-index bits, ignoring the byte-offset bits.
REQ-005 S_AXI_ACLK  in  1  single clock for all logic, rising edge.
REQ-006 S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR/3/1; S_AXI_AWREADY  out  1  AXI4-Lite write address channel; AWPROT ignored.
REQ-008 S_AXI_WDATA/WSTRB/WVALID  in  DW/DW/8/1; S_AXI_WREADY  out  1  write data channel.
REQ-009 S_AXI_BRESP/BVALID  out  2/1; S_AXI_BREADY  in  1  write response channel.
REQ-010 S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR/3/1; S_AXI_ARREADY  out  1  read address channel; ARPROT ignored.
REQ-011 S_AXI_RDATA/RRESP/RVALID  out  DW/2/1; S_AXI_RREADY  in  1  read data channel.
REQ-012 reg_out  out  C_NUM_REGS*DW  current value of every register, register i at [i*DW +: DW].
REQ-013 ro_in  in  C_NUM_REGS*DW  hardware values returned for read-only registers; ignored for RW registers.
REQ-014 wr_pulse  out  C_NUM_REGS  one-cycle strobe, bit i high the cycle after register i is updated.

Function
REQ-015 Write path SHALL accept AW and W independently, in either order or the same cycle, one outstanding write only.
REQ-016 AWREADY SHALL be high when no address is held and BVALID is low; WREADY SHALL be high when no data is held and BVALID is low.
REQ-017 Held AW/W SHALL be registered; the write SHALL commit on the edge where both address and data are available (held or handshaking that cycle).
REQ-018 On commit to an RW register, each byte lane with WSTRB=1 SHALL update and lanes with WSTRB=0 SHALL keep the old value; WSTRB=0 overall is a legal no-op with OKAY.
REQ-019 On commit to a read-only register, no state SHALL change, wr_pulse SHALL stay low and BRESP SHALL be 2'b10 (SLVERR); otherwise BRESP SHALL be 2'b00.
REQ-020 BVALID SHALL rise the cycle after commit (latency 1 from last of AW/W handshake) and hold, with BRESP stable, until BREADY; held AW/W clear at commit.
REQ-021 Write state machine SHALL be IDLE -> ADDR_HELD or DATA_HELD -> RESP, or IDLE -> RESP directly when both handshake together; RESP -> IDLE on BREADY.
REQ-022 ARREADY SHALL equal NOT RVALID; on AR handshake RDATA SHALL be captured and RVALID raised the next cycle, held stable until RREADY.
REQ-023 RDATA SHALL be ro_in slice for read-only registers, otherwise the register value; RRESP SHALL always be 2'b00.
REQ-024 Read and write to the same register committing on the same edge SHALL return the pre-write value.
REQ-025 Read and write channels SHALL operate fully concurrently with no mutual stalling.
REQ-026 Back-to-back accesses SHALL sustain one write per 2 cycles and one read per 2 cycles when BREADY/RREADY are held high.

Reset
REQ-027 While S_AXI_ARESETN is low, all registers, held address/data, state (IDLE), AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse SHALL be 0, BRESP/RRESP/RDATA 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it with no register update and no response after release.
REQ-029 First handshake SHALL be accepted no earlier than the first rising edge after S_AXI_ARESETN deasserts.

Verification
REQ-030 Defaults: write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, read back -> RDATA 0x1..0x4, all BRESP/RRESP OKAY, wr_pulse bits 0..3 each pulse once.
REQ-031 Reg1=0x11223344, write 0xAABBCCDD WSTRB=4'b0101 -> reads 0x11BB33DD.
REQ-032 WVALID 3 cycles before AWVALID (data 0xCAFE0001, addr 0x8) -> WREADY drops after W handshake, commit on AW handshake edge, BVALID next cycle, reg2=0xCAFE0001.
REQ-033 C_RO_MASK=4'b0010, ro_in reg1=0xDEADBEEF, write 0x5 to 0x4 -> BRESP SLVERR, no wr_pulse, read 0x4 returns 0xDEADBEEF.
REQ-034 BREADY held low 5 cycles with second AW/W pending -> BVALID/BRESP stable, AWREADY/WREADY low, second write commits only after first B handshake.
REQ-035 Assert reset one cycle after AR handshake -> RVALID stays 0, all registers 0 after release, no stale R beat.

Source files
------------

// File: rtl/sha3_axil_regbank.sv
// AXI4-Lite slave register bank with per-register read-only masking, byte-strobed writes,
// a flattened register view and a one-cycle update strobe per register.
module sha3_axil_regbank #(
  parameter int unsigned            C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned            C_NUM_REGS         = 4,
  parameter logic [C_NUM_REGS-1:0]  C_RO_MASK          = '0,
  localparam int unsigned           C_S_AXI_ADDR_WIDTH =
      $clog2(C_NUM_REGS) + $clog2(C_S_AXI_DATA_WIDTH / 8)
) (
  input  logic                                    S_AXI_ACLK,
  input  logic                                    S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
  input  logic [2:0]                              S_AXI_AWPROT,
  input  logic                                    S_AXI_AWVALID,
  output logic                                    S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
  input  logic                                    S_AXI_WVALID,
  output logic                                    S_AXI_WREADY,
  output logic [1:0]                              S_AXI_BRESP,
  output logic                                    S_AXI_BVALID,
  input  logic                                    S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic [2:0]                              S_AXI_ARPROT,
  input  logic                                    S_AXI_ARVALID,
  output logic                                    S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                              S_AXI_RRESP,
  output logic                                    S_AXI_RVALID,
  input  logic                                    S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_in,
  output logic [C_NUM_REGS-1:0]                   wr_pulse
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned IDX_W = $clog2(C_NUM_REGS);
  localparam int unsigned OFS_W = $clog2(NB);
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {StIdle, StAddrHeld, StDataHeld, StResp} wr_state_e;

  wr_state_e            wr_state_q, wr_state_d;
  logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [NB-1:0]        wstrb_q, wstrb_d;
  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q, rvalid_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [C_NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]        regs_q [C_NUM_REGS];
  logic [DW-1:0]        regs_d [C_NUM_REGS];
  logic [DW-1:0]        ro_arr [C_NUM_REGS];

  logic                 aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]     aw_idx_live, ar_idx, cm_idx;
  logic [DW-1:0]        cm_data;
  logic [NB-1:0]        cm_strb;

  // Byte-offset address bits and the protection fields carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[OFS_W-1:0], S_AXI_ARADDR[OFS_W-1:0]};

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_flat
    assign ro_arr[i]              = ro_in[i*DW +: DW];
    assign reg_out[i*DW +: DW]    = regs_q[i];
  end

  assign aw_hs       = S_AXI_AWVALID && awready_q;
  assign w_hs        = S_AXI_WVALID && wready_q;
  assign ar_hs       = S_AXI_ARVALID && arready_q;
  assign aw_idx_live = S_AXI_AWADDR[AW-1:OFS_W];
  assign ar_idx      = S_AXI_ARADDR[AW-1:OFS_W];

  // Commit operands come from the holding registers when that half arrived earlier.
  assign cm_idx  = (wr_state_q == StAddrHeld) ? aw_idx_q : aw_idx_live;
  assign cm_data = (wr_state_q == StDataHeld) ? wdata_q : S_AXI_WDATA;
  assign cm_strb = (wr_state_q == StDataHeld) ? wstrb_q : S_AXI_WSTRB;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    unique case (wr_state_q)
      StIdle: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
        end else if (aw_hs) begin
          aw_idx_d   = aw_idx_live;
          wr_state_d = StAddrHeld;
        end else if (w_hs) begin
          wdata_d    = S_AXI_WDATA;
          wstrb_d    = S_AXI_WSTRB;
          wr_state_d = StDataHeld;
        end
      end
      StAddrHeld: commit = w_hs;
      StDataHeld: commit = aw_hs;
      StResp: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          bresp_d    = RespOkay;
          wr_state_d = StIdle;
        end
      end
      default: wr_state_d = StIdle;
    endcase
    if (commit) begin
      wr_state_d = StResp;
      bvalid_d   = 1'b1;
      bresp_d    = C_RO_MASK[cm_idx] ? RespSlverr : RespOkay;
      aw_idx_d   = '0;
      wdata_d    = '0;
      wstrb_d    = '0;
    end
    awready_d = (wr_state_d == StIdle) || (wr_state_d == StDataHeld);
    wready_d  = (wr_state_d == StIdle) || (wr_state_d == StAddrHeld);
  end

  // The strobe marks an accepted write to an RW register, including an all-zero WSTRB.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (commit && !C_RO_MASK[cm_idx]) begin
      wr_pulse_d[cm_idx] = 1'b1;
      for (int unsigned b = 0; b < NB; b++) begin
        if (cm_strb[b]) begin
          regs_d[cm_idx][b*8 +: 8] = cm_data[b*8 +: 8];
        end
      end
    end
  end

  // Reads sample regs_q, so a same-edge write is not yet visible.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = C_RO_MASK[ar_idx] ? ro_arr[ar_idx] : regs_q[ar_idx];
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= StIdle;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      regs_q     <= '{default: '0};
    end else begin
      wr_state_q <= wr_state_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RespOkay;
  assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_sha3_axil_regbank.sv
// Scoreboard bench: two DUTs (all-RW and reg1 read-only) share stimulus; sel picks the one checked.
module tb_sha3_axil_regbank;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    awaddr = '0, araddr = '0;
  logic             awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic             bready = 1'b1, rready = 1'b1;
  logic [DW-1:0]    wdata = '0;
  logic [DW/8-1:0]  wstrb = '0;
  logic [NR*DW-1:0] ro_in = {32'h0BAD0003, 32'h0BAD0002, 32'hDEADBEEF, 32'h0BAD0000};
  logic             sel = 1'b0;

  logic             awready_v [2];
  logic             wready_v  [2];
  logic             bvalid_v  [2];
  logic [1:0]       bresp_v   [2];
  logic             arready_v [2];
  logic             rvalid_v  [2];
  logic [DW-1:0]    rdata_v   [2];
  logic [1:0]       rresp_v   [2];
  logic [NR*DW-1:0] reg_out_v [2];
  logic [NR-1:0]    pulse_v   [2];

  sha3_axil_regbank #(.C_S_AXI_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_RO_MASK(4'b0000)) dut_rw (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready_v[0]),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_v[0]),
    .S_AXI_BRESP(bresp_v[0]), .S_AXI_BVALID(bvalid_v[0]), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready_v[0]),
    .S_AXI_RDATA(rdata_v[0]), .S_AXI_RRESP(rresp_v[0]), .S_AXI_RVALID(rvalid_v[0]),
    .S_AXI_RREADY(rready),
    .reg_out(reg_out_v[0]), .ro_in(ro_in), .wr_pulse(pulse_v[0])
  );

  sha3_axil_regbank #(.C_S_AXI_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_RO_MASK(4'b0010)) dut_ro (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready_v[1]),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_v[1]),
    .S_AXI_BRESP(bresp_v[1]), .S_AXI_BVALID(bvalid_v[1]), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready_v[1]),
    .S_AXI_RDATA(rdata_v[1]), .S_AXI_RRESP(rresp_v[1]), .S_AXI_RVALID(rvalid_v[1]),
    .S_AXI_RREADY(rready),
    .reg_out(reg_out_v[1]), .ro_in(ro_in), .wr_pulse(pulse_v[1])
  );

  logic             awready, wready, bvalid, arready, rvalid;
  logic [1:0]       bresp, rresp;
  logic [DW-1:0]    rdata;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    wr_pulse;
  assign awready  = awready_v[sel];
  assign wready   = wready_v[sel];
  assign bvalid   = bvalid_v[sel];
  assign bresp    = bresp_v[sel];
  assign arready  = arready_v[sel];
  assign rvalid   = rvalid_v[sel];
  assign rdata    = rdata_v[sel];
  assign rresp    = rresp_v[sel];
  assign reg_out  = reg_out_v[sel];
  assign wr_pulse = pulse_v[sel];

  int total = 0;
  int bad = 0;
  int pulse_cnt [NR];
  logic [1:0]    exp_b_q [$];
  logic [DW-1:0] exp_r_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every B/R beat and counts update strobes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        check("b_beat_expected", 128'(exp_b_q.size() != 0), 128'(1));
        if (exp_b_q.size() != 0) check("bresp", 128'(bresp), 128'(exp_b_q.pop_front()));
      end
      if (rvalid && rready) begin
        check("r_beat_expected", 128'(exp_r_q.size() != 0), 128'(1));
        if (exp_r_q.size() != 0) check("rdata", 128'(rdata), 128'(exp_r_q.pop_front()));
        check("rresp", 128'(rresp), 128'(0));
      end
      for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
    end
  end

  task automatic clr_pulses();
    for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
  endtask

  task automatic chk_pulses(input string name, input int e0, input int e1, input int e2,
                            input int e3);
    check({name, "_p0"}, 128'(pulse_cnt[0]), 128'(e0));
    check({name, "_p1"}, 128'(pulse_cnt[1]), 128'(e1));
    check({name, "_p2"}, 128'(pulse_cnt[2]), 128'(e2));
    check({name, "_p3"}, 128'(pulse_cnt[3]), 128'(e3));
  endtask

  task automatic wr_start(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] s, input logic [1:0] er);
    exp_b_q.push_back(er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
  endtask

  task automatic rd_start(input logic [AW-1:0] a, input logic [DW-1:0] ed);
    exp_r_q.push_back(ed);
    araddr = a; arvalid = 1'b1;
  endtask

  // Called just after a rising edge; drops each valid once its handshake is seen.
  task automatic wait_hs(input string name);
    int n = 0;
    logic aw_d, w_d, ar_d;
    while ((awvalid || wvalid || arvalid) && n < 40) begin
      @(negedge clk);
      aw_d = awvalid && awready; w_d = wvalid && wready; ar_d = arvalid && arready;
      @(posedge clk); #1;
      if (aw_d) awvalid = 1'b0;
      if (w_d)  wvalid  = 1'b0;
      if (ar_d) arvalid = 1'b0;
      n++;
    end
    check({name, "_hs_timeout"}, 128'(awvalid || wvalid || arvalid), 128'(0));
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drain"}, 128'(exp_b_q.size() + exp_r_q.size()), 128'(0));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                    input logic [1:0] er);
    wr_start(a, d, s, er); wait_hs("wr"); drain("wr");
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ed);
    rd_start(a, ed); wait_hs("rd"); drain("rd");
  endtask

  initial begin
    clr_pulses();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_handshake", 128'({awready, wready, arready, bvalid, rvalid}), 128'(0));
    check("rst_reg_out", 128'(reg_out), 128'(0));
    check("rst_outputs", 128'({wr_pulse, bresp, rresp, rdata}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check("rel_awready_before_edge", 128'(awready), 128'(0));

    // All four registers written and read back.
    for (int i = 0; i < NR; i++) wr(AW'(i * 4), DW'(i + 1), 4'hF, 2'b00);
    for (int i = 0; i < NR; i++) rd(AW'(i * 4), DW'(i + 1));
    chk_pulses("t1", 1, 1, 1, 1);
    check("t1_reg_out", 128'(reg_out), {32'h4, 32'h3, 32'h2, 32'h1});

    // Partial byte strobes.
    wr(4'h4, 32'h11223344, 4'hF, 2'b00);
    wr(4'h4, 32'hAABBCCDD, 4'b0101, 2'b00);
    rd(4'h4, 32'h11BB33DD);

    // W three cycles ahead of AW.
    exp_b_q.push_back(2'b00);
    wdata = 32'hCAFE0001; wstrb = 4'hF; awaddr = 4'h8; wvalid = 1'b1;
    @(negedge clk); check("t3_wready_idle", 128'(wready), 128'(1));
    @(posedge clk); #1 wvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t3_wready_held", 128'(wready), 128'(0));
      check("t3_awready_held", 128'(awready), 128'(1));
      check("t3_bvalid_held", 128'(bvalid), 128'(0));
      @(posedge clk); #1;
    end
    awvalid = 1'b1;
    @(negedge clk); check("t3_reg2_before", 128'(reg_out[95:64]), 128'(32'h3));
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    check("t3_bvalid_after", 128'(bvalid), 128'(1));
    check("t3_reg2_after", 128'(reg_out[95:64]), 128'(32'hCAFE0001));
    @(posedge clk); #1;
    drain("t3");
    rd(4'h8, 32'hCAFE0001);

    // Stalled B channel with a second write waiting, on the read-only-mask DUT.
    sel = 1'b1; clr_pulses();
    bready = 1'b0;
    wr_start(4'h4, 32'h5, 4'hF, 2'b10); wait_hs("t4_first");
    wr_start(4'h0, 32'h7777, 4'hF, 2'b00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_bvalid", 128'(bvalid), 128'(1));
      check("t4_bresp", 128'(bresp), 128'(2'b10));
      check("t4_readies", 128'({awready, wready}), 128'(0));
      check("t4_reg0", 128'(reg_out[31:0]), 128'(32'h1));
      @(posedge clk); #1;
    end
    bready = 1'b1;
    wait_hs("t4_second"); drain("t4");
    check("t4_reg0_final", 128'(reg_out[31:0]), 128'(32'h7777));
    chk_pulses("t4", 1, 0, 0, 0);

    // Read-only register: SLVERR, no strobe, hardware value on read.
    clr_pulses();
    wr(4'h4, 32'h5, 4'hF, 2'b10);
    rd(4'h4, 32'hDEADBEEF);
    rd(4'h0, 32'h7777);
    chk_pulses("t5", 0, 0, 0, 0);
    check("t5_reg1", 128'(reg_out[63:32]), 128'(0));

    // Same-edge read and write of one register returns the old value.
    sel = 1'b0;
    wr_start(4'hC, 32'h99, 4'hF, 2'b00);
    rd_start(4'hC, 32'h4);
    wait_hs("t6"); drain("t6");
    rd(4'hC, 32'h99);

    // Reset during a held write address and a pending read beat.
    rready = 1'b0;
    awaddr = 4'h0; awvalid = 1'b1; wait_hs("t7_aw");
    araddr = 4'h4; arvalid = 1'b1; wait_hs("t7_ar");
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("t7_rst_valid", 128'({rvalid, bvalid}), 128'(0));
    check("t7_rst_regs", 128'(reg_out), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; rready = 1'b1; bready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t7_no_beat", 128'({rvalid, bvalid}), 128'(0));
    end
    check("t7_regs_after", 128'(reg_out), 128'(0));
    check("end_queues", 128'(exp_b_q.size() + exp_r_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
